jtag_dtm: RTL and testbench
===========================

// Module: jtag_dtm
// PURPOSE
// JTAG Debug Transport Module (RISC-V Debug Spec 0.13) feeding the single-hart DM's trivial DMI bus.
// Runs entirely in the system clock domain: TCK/TMS/TDI are synchronized and TCK edges are oversampled.
// So dmi_start is produced already synchronous to clk, as the DM requires.
// Implements the TAP controller plus the IDCODE, DTMCS, DMI and BYPASS registers.
// Converts DMI Update-DR into one-cycle DMI requests and returns DM read data to the scan chain.
// PARAMETERS
// IDCODE       32'h1000_0001  value loaded into the IDCODE DR on Capture-DR; bit0 must be 1
// ABITS        7              DMI address width; DMI DR width = ABITS+34 = 41
// SYNC_STAGES  2              flops in the tck/tms/tdi synchronizers
// PORTS
// clk          in   1   system clock; TCK must be <= clk/8
// rst          in   1   asynchronous, active-high reset
// tck          in   1   JTAG clock pin, asynchronous
// tms          in   1   JTAG mode select pin, asynchronous
// tdi          in   1   JTAG data in pin, asynchronous
// tdo          out  1   JTAG data out; updated on detected TCK falling edge
// tdo_en       out  1   1 while the TAP is in Shift-IR or Shift-DR
// dmi_start    out  1   one-clk request pulse to the DM
// dmi_op       out  2   1 = read, 2 = write
// dmi_address  out  7   DM register address; maps to the DM's [40:34]
// dmi_data_o   out  32  write data to the DM; maps to the DM's [33:2]
// dmi_data_i   in   32  read data from the DM; valid while dmi_finish = 1
// dmi_finish   in   1   DM completion pulse
// BEHAVIOUR
// - Reset values: tdo=0, tdo_en=0, dmi_start=0, dmi_op=0, dmi_address=0, dmi_data_o=0.
//   Reset also forces TAP=Test-Logic-Reset, IR=5'h01, dmistat=0, req_pending=0.
// - Edge detection: tck_r = last synchronized tck.
//   A rise is sync_tck & !tck_r; tms/tdi are sampled on that clk, from the same sync stage as tck.
//   A fall is !sync_tck & tck_r.
// - TAP FSM: the standard 16 IEEE 1149.1 states; advances only on a rise.
//   Five consecutive rises with tms=1 reach Test-Logic-Reset from any state.
//   Test-Logic-Reset loads IR=5'h01 (IDCODE).
// - IR is 5 bits. Shift-IR shifts LSB-first; the IR captures 5'b00001; Update-IR latches.
// - IR decode: 5'h01 IDCODE (32b), 5'h10 DTMCS (32b), 5'h11 DMI (41b); anything else is BYPASS (1b, captures 0).
// - DR operation: Capture-DR loads the selected register; each Shift-DR rise shifts tdi into the MSB
//   (shift right); tdo = DR[0] (or IR[0]), registered on the following fall.
// - DTMCS read value: {14'b0, dmihardreset=0, dmireset=0, 1'b0, idle=3'd1, dmistat[1:0], abits=6'd7, version=4'd1}.
// - DTMCS Update-DR: bit16=1 clears dmistat to 0.
//   bit17=1 clears dmistat and req_pending and drops any returned result; the DM is not reset.
// - DMI Capture-DR loads {addr_latched, result_data, op}; op = dmistat when nonzero, else 0.
// - DMI Update-DR with op = 1/2, dmistat = 0, !req_pending:
//   latch addr/data/op to the outputs; next clk dmi_start=1 for exactly one clk; req_pending=1.
// - dmi_* outputs stay stable until dmi_finish.
// - On dmi_finish: result_data <= dmi_data_i (reads only; writes keep the written data); req_pending=0.
// - DMI Update-DR or Capture-DR while req_pending: dmistat <= 3 (sticky busy).
//   Update-DR is then ignored; Capture-DR returns op=3. A request issued before the busy still completes.
// - DMI Update-DR while dmistat != 0: ignored, no request issued.
// - DMI Update-DR with op = 0 or 3: no request issued, no state change.
// - Simultaneous dmi_finish and an Update-DR in the same clk: finish is processed first, so the update is accepted.
// - rst mid-transaction: everything returns to reset values immediately. A pending DM request is abandoned.
//   A later dmi_finish while !req_pending is ignored.
// - Latency: pin edge to tap update = SYNC_STAGES+1 clk. Update-DR to dmi_start = 1 clk.
// TESTING
// - Five TMS=1 rises, then Shift-DR of 32 bits -> tdo serializes 32'h1000_0001 LSB-first; IR reads 5'b00001.
// - IR=0x10, Capture/Shift DTMCS -> 32'h0000_1071 (idle=1, abits=7, version=1).
// - IR=0x11, shift {7'h10, 32'h0000_0001, 2'd2} -> one dmi_start pulse with op=2, addr=0x10, data=1.
// - Read addr 0x11, DM returns dmi_data_i=32'h0000_0C82 -> next DMI capture shifts out data 0x00000C82 with op=0.
// - Second Update-DR before dmi_finish -> no second dmi_start; DTMCS dmistat=3.
//   Writing DTMCS bit16=1 gives dmistat=0, after which a new request succeeds.
// - Assert rst while req_pending -> dmi_start=0, TAP in Test-Logic-Reset, IR=1; a late dmi_finish causes no change.

Source files
------------

// File: rtl/jtag_dtm.sv
// jtag_dtm: JTAG Debug Transport Module for a single-hart debug module.
// The whole design runs on clk. The TCK/TMS/TDI pins are synchronized and
// TCK edges are detected by oversampling, so TCK must be at most clk/8.
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   tck, tms, tdi            JTAG pins (asynchronous to clk)
//   tdo, tdo_en              JTAG data out (changes on TCK fall), shift-state enable
//   dmi_start                one-clk request pulse to the DM
//   dmi_op                   1 = read, 2 = write
//   dmi_address, dmi_data_o  request address / write data, held until dmi_finish
//   dmi_data_i, dmi_finish   DM read data and completion pulse
module jtag_dtm #(
  parameter logic [31:0] IDCODE      = 32'h1000_0001,
  parameter int unsigned ABITS       = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tck,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             tdo_en,
  output logic             dmi_start,
  output logic [1:0]       dmi_op,
  output logic [ABITS-1:0] dmi_address,
  output logic [31:0]      dmi_data_o,
  input  logic [31:0]      dmi_data_i,
  input  logic             dmi_finish
);

  localparam int unsigned DMI_W = ABITS + 34;
  localparam int unsigned IR_W  = 5;
  localparam logic [IR_W-1:0] IR_IDCODE = 5'h01;
  localparam logic [IR_W-1:0] IR_DTMCS  = 5'h10;
  localparam logic [IR_W-1:0] IR_DMI    = 5'h11;

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI, ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PAU_DR, ST_EX2_DR,
    ST_UPD_DR, ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PAU_IR, ST_EX2_IR, ST_UPD_IR
  } tap_e;

  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
  logic                   tck_r, tck_s, tms_s, tdi_s, rise_c, fall_c;
  tap_e                   tap_q, tap_next;
  logic                   cap_dr_c, sh_dr_c, upd_dr_c, cap_ir_c, sh_ir_c, upd_ir_c, shift_en_c;
  logic [IR_W-1:0]        ir, ir_sh;
  logic [DMI_W-1:0]       dr, dr_cap_c, dr_shift_c;
  logic [31:0]            result_data, dtmcs_c;
  logic [1:0]             dmistat, cap_op_c;
  logic                   req_pending, busy_c;

  // Pin synchronizers and TCK edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_r    <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
      tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
      tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
      tck_r    <= tck_s;
    end
  end

  assign tck_s  = tck_sync[SYNC_STAGES-1];
  assign tms_s  = tms_sync[SYNC_STAGES-1];
  assign tdi_s  = tdi_sync[SYNC_STAGES-1];
  assign rise_c = tck_s & ~tck_r;
  assign fall_c = ~tck_s & tck_r;

  // TAP state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tap_q <= ST_TLR;
    else     tap_q <= tap_next;
  end

  // TAP next state, advancing only on a detected TCK rise
  always_comb begin
    tap_next = tap_q;
    if (rise_c) begin
      case (tap_q)
        ST_TLR:    tap_next = tms_s ? ST_TLR    : ST_RTI;
        ST_RTI:    tap_next = tms_s ? ST_SEL_DR : ST_RTI;
        ST_SEL_DR: tap_next = tms_s ? ST_SEL_IR : ST_CAP_DR;
        ST_CAP_DR: tap_next = tms_s ? ST_EX1_DR : ST_SH_DR;
        ST_SH_DR:  tap_next = tms_s ? ST_EX1_DR : ST_SH_DR;
        ST_EX1_DR: tap_next = tms_s ? ST_UPD_DR : ST_PAU_DR;
        ST_PAU_DR: tap_next = tms_s ? ST_EX2_DR : ST_PAU_DR;
        ST_EX2_DR: tap_next = tms_s ? ST_UPD_DR : ST_SH_DR;
        ST_UPD_DR: tap_next = tms_s ? ST_SEL_DR : ST_RTI;
        ST_SEL_IR: tap_next = tms_s ? ST_TLR    : ST_CAP_IR;
        ST_CAP_IR: tap_next = tms_s ? ST_EX1_IR : ST_SH_IR;
        ST_SH_IR:  tap_next = tms_s ? ST_EX1_IR : ST_SH_IR;
        ST_EX1_IR: tap_next = tms_s ? ST_UPD_IR : ST_PAU_IR;
        ST_PAU_IR: tap_next = tms_s ? ST_EX2_IR : ST_PAU_IR;
        ST_EX2_IR: tap_next = tms_s ? ST_UPD_IR : ST_SH_IR;
        ST_UPD_IR: tap_next = tms_s ? ST_SEL_DR : ST_RTI;
        default:   tap_next = ST_TLR;
      endcase
    end
  end

  // TAP action strobes; capture/shift act on the rise leaving the state,
  // update acts on the rise that enters Update so the DMI request goes out promptly
  always_comb begin
    cap_dr_c   = 1'b0;
    sh_dr_c    = 1'b0;
    upd_dr_c   = 1'b0;
    cap_ir_c   = 1'b0;
    sh_ir_c    = 1'b0;
    upd_ir_c   = 1'b0;
    shift_en_c = (tap_next == ST_SH_DR) || (tap_next == ST_SH_IR);
    if (rise_c) begin
      cap_dr_c = (tap_q == ST_CAP_DR);
      sh_dr_c  = (tap_q == ST_SH_DR);
      upd_dr_c = (tap_next == ST_UPD_DR);
      cap_ir_c = (tap_q == ST_CAP_IR);
      sh_ir_c  = (tap_q == ST_SH_IR);
      upd_ir_c = (tap_next == ST_UPD_IR);
    end
  end

  // Instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir    <= IR_IDCODE;
      ir_sh <= '0;
    end else begin
      if (tap_q == ST_TLR) ir <= IR_IDCODE;
      if (cap_ir_c)        ir_sh <= 5'b00001;
      else if (sh_ir_c)    ir_sh <= {tdi_s, ir_sh[IR_W-1:1]};
      if (upd_ir_c)        ir <= ir_sh;
    end
  end

  assign dtmcs_c  = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat, 6'(ABITS), 4'd1};
  assign cap_op_c = req_pending ? 2'd3 : dmistat;
  assign busy_c   = req_pending & ~dmi_finish;

  // Capture value and shift-right value of the selected data register
  always_comb begin
    dr_cap_c   = '0;
    dr_shift_c = {{(DMI_W-1){1'b0}}, tdi_s};
    case (ir)
      IR_IDCODE: begin
        dr_cap_c   = DMI_W'(IDCODE);
        dr_shift_c = {{(DMI_W-32){1'b0}}, tdi_s, dr[31:1]};
      end
      IR_DTMCS: begin
        dr_cap_c   = DMI_W'(dtmcs_c);
        dr_shift_c = {{(DMI_W-32){1'b0}}, tdi_s, dr[31:1]};
      end
      IR_DMI: begin
        dr_cap_c   = {dmi_address, result_data, cap_op_c};
        dr_shift_c = {tdi_s, dr[DMI_W-1:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           dr <= '0;
    else if (cap_dr_c) dr <= dr_cap_c;
    else if (sh_dr_c)  dr <= dr_shift_c;
  end

  // TDO changes on the detected fall; tdo_en tracks the shift states
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= shift_en_c;
      if (fall_c) tdo <= (tap_q == ST_SH_IR) ? ir_sh[0] : dr[0];
    end
  end

  // DMI request/response bookkeeping; a finish in the same clk frees the slot first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmi_start   <= 1'b0;
      dmi_op      <= 2'd0;
      dmi_address <= '0;
      dmi_data_o  <= '0;
      result_data <= '0;
      dmistat     <= 2'd0;
      req_pending <= 1'b0;
    end else begin
      dmi_start <= 1'b0;
      if (dmi_finish && req_pending) begin
        req_pending <= 1'b0;
        result_data <= (dmi_op == 2'd1) ? dmi_data_i : dmi_data_o;
      end
      if (cap_dr_c && (ir == IR_DMI) && req_pending) dmistat <= 2'd3;
      if (upd_dr_c && (ir == IR_DTMCS)) begin
        if (dr[16] || dr[17]) dmistat <= 2'd0;
        if (dr[17])           req_pending <= 1'b0;
      end
      if (upd_dr_c && (ir == IR_DMI)) begin
        if (busy_c) begin
          dmistat <= 2'd3;
        end else if ((dmistat == 2'd0) && ((dr[1:0] == 2'd1) || (dr[1:0] == 2'd2))) begin
          dmi_op      <= dr[1:0];
          dmi_data_o  <= dr[33:2];
          dmi_address <= dr[DMI_W-1:34];
          dmi_start   <= 1'b1;
          req_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_dtm.sv
// tb_jtag_dtm: drives JTAG scans against jtag_dtm with a small DM responder.
// Expected scan-out words and DMI requests are queued by the stimulus and
// checked by independent monitors.
`timescale 1ns/1ps
module tb_jtag_dtm;

  typedef struct packed {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tck = 1'b0, tms = 1'b0, tdi = 1'b0;
  logic        tdo, tdo_en, dmi_start;
  logic [1:0]  dmi_op;
  logic [6:0]  dmi_address;
  logic [31:0] dmi_data_o;
  logic [31:0] dmi_data_i = 32'd0;
  logic        dmi_finish = 1'b0;

  int tests = 0;
  int fails = 0;

  // Reference model of the DTM as seen from the scan chain
  logic [1:0]  m_dmistat = 2'd0;
  logic        m_pending = 1'b0;
  logic [31:0] m_result  = 32'd0;
  logic [6:0]  m_addr    = 7'd0;

  int          exp_n_q[$];
  logic [40:0] exp_v_q[$];
  int          exp_id_q[$];
  req_t        exp_req_q[$];
  int          scan_id = 0;
  int          issued = 0;
  int          starts = 0;

  int          dm_delay_fix = 0;
  logic        rd_force_en = 1'b0;
  logic [31:0] rd_force_val = 32'd0;
  logic        dm_busy = 1'b0;

  jtag_dtm dut (
    .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_en(tdo_en), .dmi_start(dmi_start), .dmi_op(dmi_op),
    .dmi_address(dmi_address), .dmi_data_o(dmi_data_o),
    .dmi_data_i(dmi_data_i), .dmi_finish(dmi_finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tck_cycle(input logic tms_v, input logic tdi_v);
    tms = tms_v;
    tdi = tdi_v;
    repeat (2) @(negedge clk);
    tck = 1'b1;
    repeat (5) @(negedge clk);
    tck = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) tck_cycle(1'b0, 1'b0);
  endtask

  task automatic push_scan(input int n, input logic [40:0] v);
    scan_id++;
    exp_n_q.push_back(n);
    exp_v_q.push_back(v);
    exp_id_q.push_back(scan_id);
  endtask

  task automatic tap_reset();
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic scan_ir(input logic [4:0] v);
    push_scan(5, 41'h1);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tck_cycle(i == 4, v[i]);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic scan_dr_raw(input int n, input logic [40:0] din);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < n; i++) tck_cycle(i == n - 1, din[i]);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic dr_scan(input int n, input logic [40:0] din, input logic [40:0] exp);
    push_scan(n, exp);
    scan_dr_raw(n, din);
  endtask

  task automatic dtmcs_scan(input logic [31:0] din);
    push_scan(32, 41'(32'h0000_1071 | (32'(m_dmistat) << 10)));
    if (din[16] || din[17]) m_dmistat = 2'd0;
    if (din[17])            m_pending = 1'b0;
    scan_dr_raw(32, 41'(din));
  endtask

  task automatic dmi_scan(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
    logic [1:0] cap_op;
    cap_op = m_pending ? 2'd3 : m_dmistat;
    if (m_pending) m_dmistat = 2'd3;
    push_scan(41, {m_addr, m_result, cap_op});
    if (m_pending) begin
      m_dmistat = 2'd3;
    end else if (m_dmistat == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
      m_addr    = addr;
      m_pending = 1'b1;
      issued++;
      exp_req_q.push_back('{op, addr, data});
    end
    scan_dr_raw(41, {addr, data, op});
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while ((m_pending || dm_busy) && t < limit) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (m_pending || dm_busy) begin
      fails++;
      $display("FAIL dmi_finish_timeout: still busy after %0d clks, required idle", t);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    m_dmistat = 2'd0;
    m_pending = 1'b0;
    m_result  = 32'd0;
    m_addr    = 7'd0;
    repeat (3) @(negedge clk);
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_tdo_en", 64'(tdo_en), 64'd0);
    check("rst_dmi_start", 64'(dmi_start), 64'd0);
    check("rst_dmi_op", 64'(dmi_op), 64'd0);
    check("rst_dmi_address", 64'(dmi_address), 64'd0);
    check("rst_dmi_data_o", 64'(dmi_data_o), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Scan-out monitor: collects TDO on each shifting TCK rise, compares at exit
  initial begin : scan_mon
    logic [40:0] got, ev, mask;
    int cnt, n, id;
    got = '0;
    cnt = 0;
    forever begin
      @(posedge tck);
      if (tdo_en === 1'b1) begin
        if (cnt < 41) got[cnt] = tdo;
        cnt++;
        if (tms) begin
          tests++;
          if (exp_n_q.size() == 0) begin
            fails++;
            $display("FAIL scan_unexpected: got %0d bits %h, required no scan", cnt, got);
          end else begin
            n  = exp_n_q.pop_front();
            ev = exp_v_q.pop_front();
            id = exp_id_q.pop_front();
            mask = (n >= 41) ? '1 : ((41'd1 << n) - 41'd1);
            if (cnt != n || (got & mask) !== ev) begin
              fails++;
              $display("FAIL scan%0d: got %0d bits %h, required %0d bits %h", id, cnt, got & mask, n, ev);
            end
          end
          got = '0;
          cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) if (dmi_start === 1'b1) starts++;

  // DM responder: checks each request, completes it after a delay
  initial begin : dm_model
    req_t        e;
    logic [31:0] rd;
    int          d;
    forever begin
      @(negedge clk);
      if (dmi_start === 1'b1) begin
        tests++;
        if (exp_req_q.size() == 0) begin
          fails++;
          $display("FAIL dmi_req_unexpected: got op=%0d addr=%h data=%h, required no request",
                   dmi_op, dmi_address, dmi_data_o);
          e = '{dmi_op, dmi_address, dmi_data_o};
        end else begin
          e = exp_req_q.pop_front();
          if ({dmi_op, dmi_address, dmi_data_o} !== e) begin
            fails++;
            $display("FAIL dmi_req: got op=%0d addr=%h data=%h, required op=%0d addr=%h data=%h",
                     dmi_op, dmi_address, dmi_data_o, e.op, e.addr, e.data);
          end
        end
        dm_busy = 1'b1;
        rd = rd_force_en ? rd_force_val : $urandom;
        rd_force_en = 1'b0;
        d = (dm_delay_fix != 0) ? dm_delay_fix : int'($urandom_range(1, 20));
        repeat (d) @(negedge clk);
        dmi_finish = 1'b1;
        dmi_data_i = rd;
        if (m_pending) begin
          m_result  = (e.op == 2'd1) ? rd : e.data;
          m_pending = 1'b0;
        end
        @(negedge clk);
        dmi_finish = 1'b0;
        dmi_data_i = $urandom;
        dm_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [40:0] bin;
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;

    apply_reset();

    // IDCODE after TAP reset, IR capture, then bypass delay
    tap_reset();
    dr_scan(32, 41'd0, 41'h1000_0001);
    scan_ir(5'h01);
    dr_scan(32, 41'(32'hFFFF_FFFF), 41'h1000_0001);
    scan_ir(5'h1F);
    bin = 41'($urandom_range(0, 255));
    dr_scan(8, bin, (bin << 1) & 41'hFF);

    scan_ir(5'h10);
    dtmcs_scan(32'd0);

    // Directed write then read with a known DM value
    scan_ir(5'h11);
    dmi_scan(2'd2, 7'h10, 32'h0000_0001);
    wait_idle(500);
    rd_force_val = 32'h0000_0C82;
    rd_force_en  = 1'b1;
    dmi_scan(2'd1, 7'h11, 32'd0);
    wait_idle(500);
    dmi_scan(2'd0, 7'h00, 32'd0);

    // Random reads, writes and nops
    for (int i = 0; i < 16; i++) begin
      op   = 2'($urandom_range(0, 2));
      addr = 7'($urandom);
      data = $urandom;
      dmi_scan(op, addr, data);
      wait_idle(500);
      run_idle(int'($urandom_range(0, 3)));
    end
    dmi_scan(2'd0, 7'h00, 32'd0);

    // Second update while busy, sticky dmistat, clear via DTMCS
    dm_delay_fix = 3000;
    dmi_scan(2'd2, 7'($urandom), $urandom);
    dmi_scan(2'd1, 7'($urandom), 32'd0);
    scan_ir(5'h10);
    dtmcs_scan(32'h0001_0000);
    wait_idle(4000);
    dtmcs_scan(32'd0);
    scan_ir(5'h11);
    dm_delay_fix = 0;
    dmi_scan(2'd1, 7'($urandom), 32'd0);
    wait_idle(500);
    dmi_scan(2'd0, 7'h00, 32'd0);

    // Reset in the middle of a pending request; late finish must be ignored
    dm_delay_fix = 2000;
    dmi_scan(2'd2, 7'($urandom), $urandom);
    apply_reset();
    tck_cycle(1'b0, 1'b0);
    dr_scan(32, 41'd0, 41'h1000_0001);
    wait_idle(3000);
    scan_ir(5'h11);
    dmi_scan(2'd0, 7'h00, 32'd0);
    dm_delay_fix = 0;
    dmi_scan(2'd1, 7'($urandom), 32'd0);
    wait_idle(500);
    dmi_scan(2'd0, 7'h00, 32'd0);
    run_idle(2);

    check("dmi_start_count", 64'(starts), 64'(issued));
    check("req_queue_left", 64'(exp_req_q.size()), 64'd0);
    check("scan_queue_left", 64'(exp_n_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
